evp_horner: RTL and testbench

EVP_HORNER -- requirements
Module: evp_horner

---
 rtl/evp_horner.sv | 167 ++++++++++++++++
 tb/tb_evp_horner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evp_horner.sv
// evp_horner: evaluates a polynomial of degree N at signed point x with
// Horner's rule, streaming coefficients (highest order first) from an
// external buffer with one-cycle read latency.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   start              begin an evaluation (sampled only in IDLE)
//   coef_base, degree  address of c_N and polynomial degree N
//   x                  evaluation point (two's complement)
//   rd_data            buffer read data, valid one cycle after rd_en
//   rd_en, rd_addr     buffer read strobe and address
//   rd_addr_data_EVP   read pointer after the last completed evaluation
//   result             polynomial value, held between completions
//   result_valid       one-cycle pulse when result is updated
//   busy               high in every state except IDLE
//   err                one-cycle pulse when start carries an illegal degree
module evp_horner #(
    parameter int unsigned buffer_size = 1024,
    parameter int unsigned word_size   = 16,
    parameter int unsigned max_degree  = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(buffer_size)-1:0] coef_base,
    input  logic [3:0]                     degree,
    input  logic [word_size-1:0]           x,
    input  logic [word_size-1:0]           rd_data,
    output logic                           rd_en,
    output logic [$clog2(buffer_size)-1:0] rd_addr,
    output logic [$clog2(buffer_size)-1:0] rd_addr_data_EVP,
    output logic [word_size-1:0]           result,
    output logic                           result_valid,
    output logic                           busy,
    output logic                           err
);

    localparam int unsigned AW = $clog2(buffer_size);
    localparam int unsigned W  = word_size;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state, state_d;
    logic [3:0]    k, k_d;
    logic [3:0]    deg_q, deg_d;
    logic [AW-1:0] base_q, base_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  acc, acc_d;
    logic          first, first_d;
    logic          rd_pend, rd_pend_d;
    logic          rd_en_d;
    logic [AW-1:0] rd_addr_d;
    logic [AW-1:0] ptr_d;
    logic [W-1:0]  result_d;
    logic          result_valid_d;
    logic          busy_d;
    logic          err_d;
    logic [W-1:0]  mac;

    // One Horner step on the beat currently on rd_data; the first beat just loads c_N.
    // Low word of the product is identical for signed and unsigned operands.
    assign mac = first ? rd_data : W'(acc * x_q) + rd_data;

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        k_d            = k;
        deg_d          = deg_q;
        base_d         = base_q;
        x_d            = x_q;
        acc_d          = acc;
        first_d        = first;
        rd_pend_d      = rd_en;
        rd_en_d        = 1'b0;
        rd_addr_d      = rd_addr;
        ptr_d          = rd_addr_data_EVP;
        result_d       = result;
        result_valid_d = 1'b0;
        err_d          = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (32'(degree) > max_degree) begin
                        err_d = 1'b1;
                    end else begin
                        base_d    = coef_base;
                        deg_d     = degree;
                        x_d       = x;
                        rd_addr_d = coef_base;
                        rd_en_d   = 1'b1;
                        k_d       = 4'd0;
                        first_d   = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            FETCH: begin
                if (rd_pend) begin
                    acc_d   = mac;
                    first_d = 1'b0;
                end
                if (k == deg_q) begin
                    state_d = DRAIN;
                end else begin
                    k_d       = k + 4'd1;
                    rd_addr_d = rd_addr + AW'(1);
                    rd_en_d   = 1'b1;
                end
            end
            DRAIN: begin
                // Last beat arrives now; publish so result_valid lands in DONE.
                acc_d          = mac;
                result_d       = mac;
                result_valid_d = 1'b1;
                ptr_d          = base_q + AW'(deg_q) + AW'(1);
                state_d        = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            k                <= '0;
            deg_q            <= '0;
            base_q           <= '0;
            x_q              <= '0;
            acc              <= '0;
            first            <= 1'b0;
            rd_pend          <= 1'b0;
            rd_en            <= 1'b0;
            rd_addr          <= '0;
            rd_addr_data_EVP <= '0;
            result           <= '0;
            result_valid     <= 1'b0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state            <= state_d;
            k                <= k_d;
            deg_q            <= deg_d;
            base_q           <= base_d;
            x_q              <= x_d;
            acc              <= acc_d;
            first            <= first_d;
            rd_pend          <= rd_pend_d;
            rd_en            <= rd_en_d;
            rd_addr          <= rd_addr_d;
            rd_addr_data_EVP <= ptr_d;
            result           <= result_d;
            result_valid     <= result_valid_d;
            busy             <= busy_d;
            err              <= err_d;
        end
    end

endmodule

// File: tb/tb_evp_horner.sv
// tb_evp_horner: self-checking bench for evp_horner with a behavioural
// buffer memory and a Horner reference model.
module tb_evp_horner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  coef_base;
    logic [3:0]  degree;
    logic [15:0] x;
    logic [15:0] rd_data;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [9:0]  rd_addr_data_EVP;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:1023];
    logic [15:0] exp_result = '0;
    logic [9:0]  exp_ptr = '0;

    evp_horner dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .coef_base        (coef_base),
        .degree           (degree),
        .x                (x),
        .rd_data          (rd_data),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_addr_data_EVP (rd_addr_data_EVP),
        .result           (result),
        .result_valid     (result_valid),
        .busy             (busy),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Polynomial value with coefficients c_N..c_0 at b..b+n, mod 2^16
    function automatic logic [15:0] ref_eval(input logic [9:0] b, input int n, input logic [15:0] xv);
        logic [31:0] a;
        logic [9:0]  addr;
        a = 32'd0;
        for (int i = 0; i <= n; i++) begin
            addr = 10'(b + 10'(i));
            a = (a * 32'(xv) + 32'(mem[addr])) & 32'h0000_FFFF;
        end
        return a[15:0];
    endfunction

    // One evaluation; optional extra start at cycle extra_cyc relative to T
    task automatic run_eval(input logic [9:0] b, input int n, input logic [15:0] xv,
                            input int extra_cyc, input string name);
        int          nreads;
        int          nrv;
        int          rv_cyc;
        logic [15:0] exp;
        logic [15:0] got;
        logic [9:0]  want_addr;
        nreads = 0;
        nrv    = 0;
        rv_cyc = -1;
        got    = '0;
        exp    = ref_eval(b, n, xv);
        @(negedge clk);
        start = 1'b1; coef_base = b; degree = 4'(n); x = xv;
        @(negedge clk);
        start = 1'b0; coef_base = 10'($urandom); degree = 4'($urandom); x = 16'($urandom);
        for (int c = 1; c <= n + 6; c++) begin
            if (rd_en) begin
                want_addr = 10'(b + 10'(nreads));
                checks++;
                if (rd_addr !== want_addr || c != nreads + 1) begin
                    errors++;
                    $display("FAIL %s rd_addr: cycle %0d got %0d, required %0d at cycle %0d",
                             name, c, rd_addr, want_addr, nreads + 1);
                end
                nreads++;
            end
            checks++;
            if (busy !== (c <= n + 3)) begin
                errors++;
                $display("FAIL %s busy: cycle %0d got %b, required %b", name, c, busy, (c <= n + 3));
            end
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err: cycle %0d got %b, required 0", name, c, err);
            end
            if (result_valid) begin
                nrv++;
                rv_cyc = c;
                got = result;
            end
            if (c == extra_cyc) begin
                start = 1'b1; coef_base = b + 10'd5; degree = 4'(n); x = xv + 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nreads != n + 1) begin
            errors++;
            $display("FAIL %s read_count: got %0d, required %0d", name, nreads, n + 1);
        end
        checks++;
        if (nrv != 1 || rv_cyc != n + 3) begin
            errors++;
            $display("FAIL %s result_valid: got %0d pulses last at cycle %0d, required 1 at cycle %0d",
                     name, nrv, rv_cyc, n + 3);
        end
        checks++;
        if (got !== exp || result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h (held %h), required %h", name, got, result, exp);
        end
        exp_ptr = 10'(b + 10'(n) + 10'd1);
        checks++;
        if (rd_addr_data_EVP !== exp_ptr) begin
            errors++;
            $display("FAIL %s rd_addr_data_EVP: got %0d, required %0d", name, rd_addr_data_EVP, exp_ptr);
        end
        exp_result = exp;
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({rd_en, rd_addr, rd_addr_data_EVP, result, result_valid, busy, err} !== '0) begin
            errors++;
            $display("FAIL %s outputs: got rd_en=%b rd_addr=%0d ptr=%0d result=%h rv=%b busy=%b err=%b, required all 0",
                     name, rd_en, rd_addr, rd_addr_data_EVP, result, result_valid, busy, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; coef_base = '0; degree = '0; x = '0; rd_data = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_asserted");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset_released");
    endtask

    task automatic test_directed();
        mem[0] = 16'd2; mem[1] = 16'd3; mem[2] = 16'd4;
        run_eval(10'd0, 2, 16'd5, 0, "basic");
        checks++;
        if (result !== 16'd69 || rd_addr_data_EVP !== 10'd3) begin
            errors++;
            $display("FAIL basic_const: got result %0d ptr %0d, required 69 ptr 3", result, rd_addr_data_EVP);
        end
        mem[1022] = 16'd1; mem[1023] = 16'd0; mem[0] = 16'd0; mem[1] = 16'd1;
        run_eval(10'd1022, 3, 16'd2, 0, "wrap");
        checks++;
        if (result !== 16'd9 || rd_addr_data_EVP !== 10'd2) begin
            errors++;
            $display("FAIL wrap_const: got result %0d ptr %0d, required 9 ptr 2", result, rd_addr_data_EVP);
        end
        mem[100] = 16'hFFF9;
        run_eval(10'd100, 0, 16'd3, 0, "degree0");
        checks++;
        if (result !== 16'hFFF9) begin
            errors++;
            $display("FAIL degree0_const: got %h, required fff9", result);
        end
        mem[200] = 16'd256; mem[201] = 16'd0;
        run_eval(10'd200, 1, 16'd256, 0, "truncate");
        checks++;
        if (result !== 16'd0) begin
            errors++;
            $display("FAIL truncate_const: got %h, required 0000", result);
        end
    endtask

    task automatic test_busy_start();
        mem[300] = 16'd1; mem[301] = 16'd1; mem[302] = 16'd1;
        run_eval(10'd300, 2, 16'hFFFF, 2, "start_while_busy");
        checks++;
        if (result !== 16'd1) begin
            errors++;
            $display("FAIL start_while_busy_const: got %h, required 0001", result);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 4; i++) begin
            n = i * 3;
            for (int j = 0; j <= n; j++) mem[400 + j] = 16'($urandom);
            run_eval(10'd400, n, 16'($urandom), n + 3, "start_in_done");
        end
    endtask

    task automatic test_random();
        logic [9:0] b;
        int         n;
        for (int i = 0; i < 25; i++) begin
            for (int j = 0; j < 1024; j++) mem[j] = 16'($urandom);
            b = (i % 3 == 0) ? 10'(1024 - $urandom_range(1, 6)) : 10'($urandom);
            n = $urandom_range(0, 10);
            run_eval(b, n, 16'($urandom), 0, "random");
        end
    endtask

    task automatic test_err();
        int n;
        for (int i = 0; i < 3; i++) begin
            n = (i == 0) ? 12 : $urandom_range(11, 15);
            @(negedge clk);
            start = 1'b1; coef_base = 10'($urandom); degree = 4'(n); x = 16'($urandom);
            @(negedge clk);
            start = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                checks++;
                if (err !== (c == 1) || rd_en !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bad_degree cycle %0d: got err=%b rd_en=%b busy=%b rv=%b, required err=%b others 0",
                             c, err, rd_en, busy, result_valid, (c == 1));
                end
                @(negedge clk);
            end
            checks++;
            if (result !== exp_result || rd_addr_data_EVP !== exp_ptr) begin
                errors++;
                $display("FAIL bad_degree_hold: got result %h ptr %0d, required %h ptr %0d",
                         result, rd_addr_data_EVP, exp_result, exp_ptr);
            end
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < 5; j++) mem[500 + j] = 16'($urandom);
        @(negedge clk);
        start = 1'b1; coef_base = 10'd500; degree = 4'd4; x = 16'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_zero("abort_immediate");
        @(negedge clk);
        rst = 1'b1;
        exp_result = '0;
        exp_ptr = '0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: got rv=%b busy=%b rd_en=%b, required 0",
                         c, result_valid, busy, rd_en);
            end
            @(negedge clk);
        end
        check_idle_zero("abort_after");
        run_eval(10'd500, 4, 16'd3, 0, "after_abort");
    endtask

    initial begin
        for (int j = 0; j < 1024; j++) mem[j] = '0;
        test_reset();
        test_directed();
        test_busy_start();
        test_err();
        test_back_to_back();
        test_random();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
